// File: rtl/rtr_sink_pkg.sv
// Shared constants and helpers for the router VC sink datapath.
// Channel word layout (MSB first): {valid, vc_idx[VCW], head, tail, data[FDW]};
// the offsets below are relative to the top of the data field.
package rtr_sink_pkg;

    // Width of a VC index; a single-VC build still carries one index bit.
    function automatic int vcw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_TAIL_OFS = 0;
    localparam int CH_HEAD_OFS = 1;
    localparam int CH_VC_OFS   = 2;

    // Bit positions inside the per-cycle error vector.
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int NUM_ERR = 2;

endpackage

// File: rtl/rtr_matrix_arbiter.sv
// Purpose: matrix arbiter, one-hot grant among requesters, least-recently-granted wins.
// Latency: grant is combinational from req; priority matrix updates on the clock edge.
// Backpressure: none; priority only moves when update is asserted with a live grant.
// Ports: clk, reset (async active-high), req[NUM_PORTS], update, gnt[NUM_PORTS].
module rtr_matrix_arbiter #(
    parameter int NUM_PORTS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 update,
    output logic [NUM_PORTS-1:0] gnt
);

    // prio[i][j] = 1 means requester i beats requester j. The matrix is kept
    // antisymmetric, so at most one requester is unblocked.
    logic [NUM_PORTS-1:0] prio [NUM_PORTS];
    logic [NUM_PORTS-1:0] blocked;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (j != i && req[j] && prio[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        gnt = req & ~blocked;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    prio[i][j] <= (i < j);
                end
            end
        end else if (update && |gnt) begin
            // Winner drops below everyone else: clear its row, set its column.
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (i != j && gnt[i]) prio[i][j] <= 1'b0;
                    if (i != j && gnt[j]) prio[i][j] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rtr_vc_sink_core.sv
// Purpose: router ejection sink; registers the flit channel, buffers per-VC FIFOs, releases one flit per consume.
// Latency: channel to pop 2 cycles (1 with RTR_SINK_BYPASS_EN defined); credit 1 cycle after pop.
// Backpressure: flits wait while consume_in=0; push into a full VC without a same-VC pop drops and flags error.
// Ports: clk, reset (async active-high), channel_in {valid,vc,head,tail,data}, consume_in,
//        pop_valid/sel/data/head/tail_out, empty_ivc_out, flow_ctrl_out {valid,vc}, error_out.
// Optional macro RTR_SINK_BYPASS_EN: a flit arriving at an empty VC may pop in its arrival cycle.
module rtr_vc_sink_core
    import rtr_sink_pkg::*;
#(
    parameter  int NUM_VCS         = 8,
    parameter  int BUFFER_SIZE     = 64,
    parameter  int FLIT_DATA_WIDTH = 64,
    localparam int VCW             = vcw_f(NUM_VCS),
    localparam int CHW             = 1 + VCW + 2 + FLIT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHW-1:0]             channel_in,
    input  logic                       consume_in,
    output logic                       pop_valid_out,
    output logic [NUM_VCS-1:0]         pop_sel_out,
    output logic [FLIT_DATA_WIDTH-1:0] pop_data_out,
    output logic                       pop_head_out,
    output logic                       pop_tail_out,
    output logic [NUM_VCS-1:0]         empty_ivc_out,
    output logic [VCW:0]               flow_ctrl_out,
    output logic                       error_out
);

    localparam int FDW   = FLIT_DATA_WIDTH;
    localparam int DEPTH = BUFFER_SIZE / NUM_VCS;
    localparam int DW    = $clog2(DEPTH);
    localparam int ENTW  = FDW + 2;                 // stored entry {head, tail, data}
    localparam logic [DW:0] FULL_CNT = (DW+1)'(DEPTH);

    function automatic logic [VCW-1:0] enc(input logic [NUM_VCS-1:0] oh);
        logic [VCW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            if (oh[i]) r = r | VCW'(i);
        end
        return r;
    endfunction

    // ---------------- input stage ----------------
    logic [CHW-1:0] chan_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chan_q <= '0;
        else       chan_q <= channel_in;
    end

    logic               flit_valid;
    logic [VCW-1:0]     flit_vc;
    logic               flit_head;
    logic               flit_tail;
    logic [FDW-1:0]     flit_data;
    logic [NUM_VCS-1:0] sel_ivc;

    assign flit_data  = chan_q[FDW-1:0];
    assign flit_tail  = chan_q[FDW+CH_TAIL_OFS];
    assign flit_head  = chan_q[FDW+CH_HEAD_OFS];
    assign flit_vc    = chan_q[FDW+CH_VC_OFS +: VCW];
    assign flit_valid = chan_q[CHW-1];

    // One-hot target VC, already qualified by valid.
    always_comb begin
        sel_ivc = '0;
        if (flit_valid && int'(flit_vc) < NUM_VCS) sel_ivc[flit_vc] = 1'b1;
    end

    // ---------------- per-VC FIFO state ----------------
    logic [ENTW-1:0] mem    [NUM_VCS][DEPTH];
    logic [DW-1:0]   rd_ptr [NUM_VCS];
    logic [DW-1:0]   wr_ptr [NUM_VCS];
    logic [DW:0]     count  [NUM_VCS];

    logic [NUM_VCS-1:0] empty_ivc, full_ivc, req_ivc, grant, pop_ivc;
    logic [NUM_VCS-1:0] byp_ivc, rd_ivc, wr_ivc, ovf_ivc, udf_ivc;
    logic [NUM_ERR-1:0] err_now;
    logic               gnt;
    logic [ENTW-1:0]    pop_entry;

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            empty_ivc[v] = (count[v] == '0);
            full_ivc[v]  = (count[v] == FULL_CNT);
        end
    end

`ifdef RTR_SINK_BYPASS_EN
    assign req_ivc = ~empty_ivc | sel_ivc;
`else
    assign req_ivc = ~empty_ivc;
`endif

    assign gnt = consume_in & (|req_ivc);

    rtr_matrix_arbiter #(
        .NUM_PORTS (NUM_VCS)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_ivc),
        .update (gnt),
        .gnt    (grant)
    );

    assign pop_ivc = gnt ? grant : '0;

`ifdef RTR_SINK_BYPASS_EN
    // Arriving flit at an empty VC goes straight out and is never stored.
    assign byp_ivc = pop_ivc & sel_ivc & empty_ivc;
`else
    assign byp_ivc = '0;
`endif

    assign rd_ivc  = pop_ivc & ~empty_ivc;
    assign udf_ivc = pop_ivc & empty_ivc & ~byp_ivc;
    // A same-cycle pop frees the slot, so a full VC can still accept.
    assign ovf_ivc = sel_ivc & full_ivc & ~pop_ivc;
    assign wr_ivc  = sel_ivc & ~byp_ivc & ~ovf_ivc;

    always_comb begin
        pop_entry = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (pop_ivc[v]) begin
                if (byp_ivc[v])        pop_entry = {flit_head, flit_tail, flit_data};
                else if (!empty_ivc[v]) pop_entry = mem[v][rd_ptr[v]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++) begin
            if (wr_ivc[v]) mem[v][wr_ptr[v]] <= {flit_head, flit_tail, flit_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (wr_ivc[v]) wr_ptr[v] <= wr_ptr[v] + DW'(1);
                if (rd_ivc[v]) rd_ptr[v] <= rd_ptr[v] + DW'(1);
                case ({wr_ivc[v], rd_ivc[v]})
                    2'b10:   count[v] <= count[v] + (DW+1)'(1);
                    2'b01:   count[v] <= count[v] - (DW+1)'(1);
                    default: count[v] <= count[v];
                endcase
            end
        end
    end

    // ---------------- registered side outputs ----------------
    always_comb begin
        err_now          = '0;
        err_now[ERR_OVF] = |ovf_ivc;
        err_now[ERR_UDF] = |udf_ivc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_out     <= 1'b0;
            flow_ctrl_out <= '0;
        end else begin
            error_out     <= |err_now;
            flow_ctrl_out <= gnt ? {1'b1, enc(grant)} : '0;
        end
    end

    assign pop_valid_out = gnt;
    assign pop_sel_out   = pop_ivc;
    assign pop_head_out  = pop_entry[ENTW-1];
    assign pop_tail_out  = pop_entry[ENTW-2];
    assign pop_data_out  = pop_entry[FDW-1:0];
    assign empty_ivc_out = empty_ivc;

endmodule

// File: tb/tb_rtr_vc_sink_core.sv
// Directed bench for rtr_vc_sink_core with a pop scoreboard and credit check.
module tb_rtr_vc_sink_core;

    localparam int NV  = 8;
    localparam int VW  = 3;
    localparam int FDW = 64;
    localparam int CHW = 1 + VW + 2 + FDW;

    logic           clk = 1'b0;
    logic           reset;
    logic [CHW-1:0] channel_in;
    logic           consume_in;
    logic           pop_valid_out;
    logic [NV-1:0]  pop_sel_out;
    logic [FDW-1:0] pop_data_out;
    logic           pop_head_out;
    logic           pop_tail_out;
    logic [NV-1:0]  empty_ivc_out;
    logic [VW:0]    flow_ctrl_out;
    logic           error_out;

    rtr_vc_sink_core dut (
        .clk           (clk),
        .reset         (reset),
        .channel_in    (channel_in),
        .consume_in    (consume_in),
        .pop_valid_out (pop_valid_out),
        .pop_sel_out   (pop_sel_out),
        .pop_data_out  (pop_data_out),
        .pop_head_out  (pop_head_out),
        .pop_tail_out  (pop_tail_out),
        .empty_ivc_out (empty_ivc_out),
        .flow_ctrl_out (flow_ctrl_out),
        .error_out     (error_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VW-1:0]  vc;
        logic           head;
        logic           tail;
        logic [FDW-1:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [VW:0] exp_cred;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [VW-1:0] vc, input logic h,
                         input logic t, input logic [FDW-1:0] d, input bit expect_pop);
        exp_t e;
        channel_in = {vld, vc, h, t, d};
        if (vld && expect_pop) begin
            e.vc = vc; e.head = h; e.tail = t; e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic idle_chan();
        channel_in = '0;
    endtask

    // Negedge sample: check credit from last cycle's expected pop, then score any pop.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        check("credit", flow_ctrl_out, exp_cred);
        if (pop_valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", pop_valid_out, 1'b0);
                exp_cred = '0;
            end else begin
                e = sb.pop_front();
                check("pop_sel",  pop_sel_out,  NV'(1) << e.vc);
                check("pop_data", pop_data_out, e.data);
                check("pop_head", pop_head_out, e.head);
                check("pop_tail", pop_tail_out, e.tail);
                exp_cred = {1'b1, e.vc};
            end
        end else begin
            check("idle_sel",  pop_sel_out,  '0);
            check("idle_data", pop_data_out, '0);
            exp_cred = '0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        channel_in = '0;
        consume_in = 1'b0;
        sb.delete();
        exp_cred   = '0;
        advance();
        advance();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [FDW-1:0] d;

        // ---------------- reset state ----------------
        reset = 1'b1; channel_in = '0; consume_in = 1'b0; exp_cred = '0;
        advance();
        check("rst_pop_valid", pop_valid_out, 1'b0);
        check("rst_pop_sel",   pop_sel_out,   '0);
        check("rst_pop_data",  pop_data_out,  '0);
        check("rst_empty",     empty_ivc_out, 8'hFF);
        check("rst_flow",      flow_ctrl_out, '0);
        check("rst_error",     error_out,     1'b0);
        do_reset();

        // ---------------- single flit vc2 ----------------
`ifdef RTR_SINK_BYPASS_EN
        lat = 1;
`else
        lat = 2;
`endif
        consume_in = 1'b1;
        d = {$urandom, $urandom};
        drive(1'b1, 3'd2, 1'b1, 1'b1, d, 1'b1);
        for (int i = 0; i <= lat; i++) begin
            sample();
            check("t1_pop_valid_lat", pop_valid_out, (i == lat));
            if (i == lat) check("t1_sel", pop_sel_out, 8'b0000_0100);
            advance();
            idle_chan();
        end
        sample();
        check("t1_credit", flow_ctrl_out, {1'b1, 3'd2});
        advance();
        check("t1_drained", 32'(sb.size()), 32'd0);

        // ---------------- fill vc0, overflow ----------------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'd0, (k == 0), (k == 7), {32'hA0A0_0000, 32'(k)}, 1'b1);
            cycle();
        end
        idle_chan();
        sample();
        check("t2_err_c8", error_out, 1'b0);
        advance();
        sample();
        check("t2_full_empty", empty_ivc_out, 8'hFE);
        check("t2_err_full", error_out, 1'b0);
        check("t2_hold_valid", pop_valid_out, 1'b0);
        check("t2_hold_flow", flow_ctrl_out, '0);
        advance();
        drive(1'b1, 3'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        cycle();
        idle_chan();
        sample();
        check("t2_err_pre", error_out, 1'b0);
        advance();
        sample();
        check("t2_overflow", error_out, 1'b1);
        advance();
        sample();
        check("t2_err_clear", error_out, 1'b0);
        check("t2_still_empty", empty_ivc_out, 8'hFE);
        advance();
        consume_in = 1'b1;
        drain("t2_drain", 20);
        cycle();
        cycle();
        check("t2_all_empty", empty_ivc_out, 8'hFF);

        // ---------------- round robin across vc1/3/5 ----------------
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int v = 1; v <= 5; v += 2) begin
                drive(1'b1, VW'(v), 1'b1, 1'b1, {$urandom, $urandom}, 1'b1);
                cycle();
            end
        end
        idle_chan();
        cycle();
        cycle();
        consume_in = 1'b1;
        drain("t3_drain", 10);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t3_idle", pop_valid_out, 1'b0);
            advance();
        end

        // ---------------- same-VC push+pop stream ----------------
        do_reset();
        drive(1'b1, 3'd4, 1'b1, 1'b0, {$urandom, $urandom}, 1'b1);
        cycle();
        drive(1'b1, 3'd4, 1'b0, 1'b0, {$urandom, $urandom}, 1'b1);
        cycle();
        idle_chan();
        cycle();
        drive(1'b1, 3'd4, 1'b0, 1'b0, {$urandom, $urandom}, 1'b1);
        cycle();
        consume_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'd4, 1'b0, (i == 19), {$urandom, $urandom}, 1'b1);
            sample();
            check("t4_pop_each", pop_valid_out, 1'b1);
            check("t4_nonempty", empty_ivc_out, 8'hEF);
            advance();
        end
        idle_chan();
        sample();
        check("t4_steady_tail", empty_ivc_out, 8'hEF);
        advance();
        drain("t4_drain", 10);
        check("t4_empty", empty_ivc_out, 8'hFF);

        // ---------------- reset mid-stream ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd6, 1'b0, 1'b0, {$urandom, $urandom}, 1'b0);
            cycle();
        end
        consume_in = 1'b1;
        reset = 1'b1;
        #2;
        check("t5_rst_empty", empty_ivc_out, 8'hFF);
        check("t5_rst_valid", pop_valid_out, 1'b0);
        check("t5_rst_flow",  flow_ctrl_out, '0);
        check("t5_rst_err",   error_out,     1'b0);
        idle_chan();
        sb.delete();
        exp_cred = '0;
        advance();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t5_no_old_pop", pop_valid_out, 1'b0);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
